// File: rtl/vred_unit.sv
// Sequential vector reduction: folds one 128-bit vector register into a SEW-wide scalar,
// one element per cycle, and returns it over a valid/ready handshake.
module vred_unit (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] reg_in,
   input  logic [127:0] reg_scalar_in,
   input  logic [2:0]   vred_op,
   input  logic [2:0]   SEW,
   input  logic [4:0]   vl,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] scalar_out,
   output logic         err
);

   localparam int VLEN      = 128;
   localparam int NELEM_MAX = VLEN / 8;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t       state_q, state_d;
   logic [127:0] reg_q, reg_d;
   logic [127:0] acc_q, acc_d;
   logic [2:0]   op_q, op_d;
   logic [2:0]   sew_q, sew_d;
   logic [4:0]   vl_eff_q, vl_eff_d;
   logic [4:0]   idx_q, idx_d;
   logic         err_q, err_d;

   logic         accept;
   logic         sew_ok_in;
   logic [4:0]   lim_in;
   logic [4:0]   vl_eff_in;
   logic [127:0] mask_in;
   logic [127:0] mask_q;
   logic [127:0] signbit_q;
   logic [7:0]   shamt;
   logic [127:0] elem;
   logic [127:0] alu_res;
   logic         last_elem;

   function automatic logic [127:0] sew_mask(input logic [2:0] s);
      logic [127:0] m;
      case (s)
         3'd0:    m = {120'd0, 8'hFF};
         3'd1:    m = {112'd0, 16'hFFFF};
         3'd2:    m = {96'd0, 32'hFFFF_FFFF};
         3'd3:    m = {64'd0, {64{1'b1}}};
         3'd4:    m = {128{1'b1}};
         default: m = '0;
      endcase
      return m;
   endfunction

   // Request-side decode: element count is clamped to what fits in one register.
   always_comb begin
      accept    = in_valid && in_ready;
      sew_ok_in = (SEW <= 3'd4);
      lim_in    = 5'(NELEM_MAX) >> SEW;
      vl_eff_in = (vl > lim_in) ? lim_in : vl;
      mask_in   = sew_mask(SEW);
   end

   // Element extraction and reduction step, all values kept masked to W bits.
   always_comb begin
      mask_q    = sew_mask(sew_q);
      signbit_q = mask_q ^ (mask_q >> 1);
      shamt     = 8'(idx_q) << (3'd3 + sew_q);
      elem      = (reg_q >> shamt) & mask_q;
      alu_res   = acc_q;
      case (op_q)
         3'b000: alu_res = (acc_q + elem) & mask_q;
         3'b001: alu_res = acc_q & elem;
         3'b010: alu_res = acc_q | elem;
         3'b011: alu_res = acc_q ^ elem;
         3'b100: if (elem < acc_q) alu_res = elem;
         3'b101: if ((elem ^ signbit_q) < (acc_q ^ signbit_q)) alu_res = elem;
         3'b110: if (elem > acc_q) alu_res = elem;
         3'b111: if ((elem ^ signbit_q) > (acc_q ^ signbit_q)) alu_res = elem;
         default: alu_res = acc_q;
      endcase
      last_elem = ((idx_q + 5'd1) == vl_eff_q);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         reg_q    <= '0;
         acc_q    <= '0;
         op_q     <= '0;
         sew_q    <= '0;
         vl_eff_q <= '0;
         idx_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         reg_q    <= reg_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         sew_q    <= sew_d;
         vl_eff_q <= vl_eff_d;
         idx_q    <= idx_d;
         err_q    <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!sew_ok_in || (vl_eff_in == 5'd0)) state_d = S_DONE;
               else                                   state_d = S_RUN;
            end
         end
         S_RUN:   if (last_elem) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      reg_d    = reg_q;
      acc_d    = acc_q;
      op_d     = op_q;
      sew_d    = sew_q;
      vl_eff_d = vl_eff_q;
      idx_d    = idx_q;
      err_d    = err_q;
      if (state_q == S_IDLE && accept) begin
         reg_d = reg_in;
         op_d  = vred_op;
         sew_d = SEW;
         idx_d = '0;
         if (sew_ok_in) begin
            acc_d    = reg_scalar_in & mask_in;
            vl_eff_d = vl_eff_in;
            err_d    = 1'b0;
         end else begin
            acc_d    = '0;
            vl_eff_d = '0;
            err_d    = 1'b1;
         end
      end else if (state_q == S_RUN) begin
         acc_d = alu_res;
         idx_d = idx_q + 5'd1;
      end
   end

   // Outputs
   always_comb begin
      in_ready   = (state_q == S_IDLE) && !rst;
      out_valid  = (state_q == S_DONE);
      scalar_out = out_valid ? acc_q : '0;
      err        = out_valid && err_q;
   end

endmodule

// File: tb/tb_vred_unit.sv
// Self-checking bench for vred_unit: scoreboard of expected scalars, latency and handshake checks.
module tb_vred_unit;
   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] reg_in;
   logic [127:0] reg_scalar_in;
   logic [2:0]   vred_op;
   logic [2:0]   SEW;
   logic [4:0]   vl;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] scalar_out;
   logic         err;

   int vectors     = 0;
   int miscompares = 0;
   logic [128:0] sb_q[$];

   always #5 clk = ~clk;

   vred_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .reg_in(reg_in), .reg_scalar_in(reg_scalar_in), .vred_op(vred_op),
      .SEW(SEW), .vl(vl), .out_valid(out_valid), .out_ready(out_ready),
      .scalar_out(scalar_out), .err(err)
   );

   function automatic logic [127:0] model(input logic [127:0] r, input logic [127:0] s,
                                          input logic [2:0] op, input logic [2:0] sew,
                                          input logic [4:0] vlr);
      int w, n;
      logic [127:0] m, acc, e;
      logic signed [127:0] se, sacc;
      w = 8 << sew;
      n = 16 >> sew;
      if (int'(vlr) < n) n = int'(vlr);
      m = {128{1'b1}};
      if (w < 128) m = (128'd1 << w) - 128'd1;
      acc = s & m;
      for (int k = 0; k < n; k++) begin
         e    = (r >> (w * k)) & m;
         se   = $signed(e << (128 - w)) >>> (128 - w);
         sacc = $signed(acc << (128 - w)) >>> (128 - w);
         case (op)
            3'd0: acc = (acc + e) & m;
            3'd1: acc = acc & e;
            3'd2: acc = acc | e;
            3'd3: acc = acc ^ e;
            3'd4: if (e < acc) acc = e;
            3'd5: if (se < sacc) acc = e;
            3'd6: if (e > acc) acc = e;
            default: if (se > sacc) acc = e;
         endcase
      end
      return acc;
   endfunction

   // Drives one request, waits for the result and checks latency, data and err.
   task automatic run_req(input logic [127:0] r, input logic [127:0] s, input logic [2:0] op,
                          input logic [2:0] sew, input logic [4:0] vlr,
                          input logic [127:0] exp_d, input logic exp_e, input int exp_lat,
                          input string name);
      int n;
      logic [128:0] e;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s in_ready before request: got %b want 1", name, in_ready);
      end
      in_valid = 1'b1; reg_in = r; reg_scalar_in = s; vred_op = op; SEW = sew; vl = vlr;
      sb_q.push_back({exp_e, exp_d});
      @(posedge clk); #1;
      // Scramble the fields while busy; only latched copies may matter.
      in_valid = 1'b0; reg_in = ~r; reg_scalar_in = ~s; vred_op = ~op; SEW = 3'd1; vl = 5'd31;
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      vectors++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL %s timeout: out_valid never rose within %0d cycles", name, n);
         void'(sb_q.pop_front());
         return;
      end
      vectors++;
      if (n != exp_lat) begin
         miscompares++;
         $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
      end
      e = sb_q.pop_front();
      vectors++;
      if (scalar_out !== e[127:0]) begin
         miscompares++;
         $display("FAIL %s data: got %h want %h", name, scalar_out, e[127:0]);
      end
      vectors++;
      if (err !== e[128]) begin
         miscompares++;
         $display("FAIL %s err: got %b want %b", name, err, e[128]);
      end
      $display("txn %s: scalar_out=%h err=%b latency=%0d", name, scalar_out, err, n);
      if (out_ready === 1'b1) begin
         @(posedge clk); #1;
         vectors++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s post-handshake: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      reg_in = '0; reg_scalar_in = '0; vred_op = '0; SEW = '0; vl = '0;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset in_ready during rst: got %b want 0", in_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || scalar_out !== 128'd0 || err !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset state: out_valid=%b scalar_out=%h err=%b in_ready=%b want 0/0/0/0",
                  out_valid, scalar_out, err, in_ready);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset release in_ready: got %b want 1", in_ready);
      end
      $display("txn reset: done");
   endtask

   task automatic test_sum();
      run_req({16{8'h01}}, 128'h05, 3'd0, 3'd0, 5'd16, 128'h15, 1'b0, 16, "sum_bytes");
      run_req({120'h0, 8'hFF}, 128'h01, 3'd0, 3'd0, 5'd1, 128'h00, 1'b0, 1, "sum_wrap8");
      run_req(128'h1, {128{1'b1}}, 3'd0, 3'd4, 5'd5, 128'h0, 1'b0, 1, "sum_wrap128");
   endtask

   task automatic test_minmax();
      logic [127:0] r, s;
      r = 128'h00000000_80000000_7FFFFFFF_FFFFFFFF;
      s = {96'hDEADBEEF_CAFEF00D_12345678, 32'h80000000};
      run_req(r, s, 3'd7, 3'd2, 5'd4, 128'h7FFFFFFF, 1'b0, 4, "max32");
      run_req(r, s, 3'd6, 3'd2, 5'd4, 128'hFFFFFFFF, 1'b0, 4, "maxu32");
      run_req(r, s, 3'd4, 3'd2, 5'd4, 128'h00000000, 1'b0, 4, "minu32");
      run_req(r, s, 3'd5, 3'd2, 5'd4, 128'h80000000, 1'b0, 4, "min32_tie");
      run_req(r, s, 3'd1, 3'd2, 5'd4, 128'h00000000, 1'b0, 4, "and32");
      run_req(r, s, 3'd2, 3'd2, 5'd4, 128'hFFFFFFFF, 1'b0, 4, "or32");
      run_req(r, s, 3'd3, 3'd2, 5'd4, 128'h80000000, 1'b0, 4, "xor32");
      r = 128'hFFFF_FFFF_FFFF_FFFF_8000_0010_0002_0003;
      run_req(r, 128'h7FFF, 3'd5, 3'd1, 5'd3, 128'h0002, 1'b0, 3, "min16_vl3");
   endtask

   task automatic test_clamp();
      run_req({16{8'h11}}, 128'hAB, 3'd0, 3'd0, 5'd0, 128'hAB, 1'b0, 0, "empty_vl0");
      run_req({64'h2, 64'h1}, 128'h10, 3'd0, 3'd3, 5'd20, 128'h13, 1'b0, 2, "clamp64");
   endtask

   task automatic test_illegal();
      run_req({16{8'h5A}}, 128'h77, 3'd0, 3'd5, 5'd4, 128'h0, 1'b1, 0, "illegal_sew5");
      run_req({16{8'h5A}}, 128'h77, 3'd6, 3'd7, 5'd16, 128'h0, 1'b1, 0, "illegal_sew7");
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      run_req({112'h0, 16'h2211}, 128'h0, 3'd0, 3'd0, 5'd2, 128'h33, 1'b0, 2, "stall_sum");
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         reg_in = {16{8'hEE}}; SEW = 3'd0; vl = 5'd0; reg_scalar_in = 128'h99;
         @(posedge clk); #1;
         vectors++;
         if (out_valid !== 1'b1 || scalar_out !== 128'h33 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall cycle %0d: out_valid=%b scalar_out=%h in_ready=%b want 1/33/0",
                     i, out_valid, scalar_out, in_ready);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL stall release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stall pulses leaked: out_valid=%b want 0", out_valid);
      end
      $display("txn stall_release: in_ready=%b out_valid=%b", in_ready, out_valid);
   endtask

   task automatic test_reset_mid_run();
      int seen;
      in_valid = 1'b1; reg_in = {16{8'h01}}; reg_scalar_in = '0; vred_op = 3'd0; SEW = 3'd0; vl = 5'd16;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midrun in_ready during rst: got %b want 0", in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || scalar_out !== 128'd0) begin
         miscompares++;
         $display("FAIL midrun after rst: out_valid=%b in_ready=%b scalar_out=%h want 0/1/0",
                  out_valid, in_ready, scalar_out);
      end
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL midrun stale output: out_valid high %0d cycles want 0", seen);
      end
      $display("txn reset_mid_run: stale_cycles=%0d", seen);
   endtask

   task automatic test_random();
      logic [127:0] r, s;
      logic [2:0] op, sew;
      logic [4:0] vlr;
      int lat;
      for (int i = 0; i < 10; i++) begin
         r   = {$urandom, $urandom, $urandom, $urandom};
         s   = {$urandom, $urandom, $urandom, $urandom};
         op  = 3'($urandom_range(0, 7));
         sew = 3'($urandom_range(0, 4));
         vlr = 5'($urandom_range(0, 20));
         lat = 16 >> sew;
         if (int'(vlr) < lat) lat = int'(vlr);
         run_req(r, s, op, sew, vlr, model(r, s, op, sew, vlr), 1'b0, lat, "random");
      end
   endtask

   initial begin
      test_reset();
      test_sum();
      test_minmax();
      test_clamp();
      test_illegal();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard leftover: got %0d entries want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
